// File: rtl/maxpool_relu_ctrl_pkg.sv
// Shared definitions for the max-pool + ReLU stage: FSM state encoding,
// default bus widths and the value ReLU substitutes for negative maxima.
package maxpool_relu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DW_DEF     = 16;
  localparam int AW_DEF     = 20;
  localparam int IN_DIM_DEF = 256;

  // Written in place of any negative window maximum.
  localparam int RELU_ZERO  = 0;

endpackage

// File: rtl/maxpool_relu_ctrl_if.sv
// Bus bundle of the max-pool + ReLU stage.
//   start          : launch request (conv controller done)
//   RAM_Q/A/OE     : conv RAM read port (one-cycle read latency)
//   POOL_A/D/WE    : pool RAM write port
//   busy/done      : status
// Modport master : the pool controller (drives both RAM buses and status).
// Modport slave  : the environment (start source, conv RAM, pool RAM).
interface maxpool_relu_ctrl_if
  import maxpool_relu_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          start;
  logic [DW-1:0] RAM_Q;
  logic [AW-1:0] RAM_A;
  logic          RAM_OE;
  logic [AW-1:0] POOL_A;
  logic [DW-1:0] POOL_D;
  logic          POOL_WE;
  logic          busy;
  logic          done;

  modport master (
    input  start, RAM_Q,
    output RAM_A, RAM_OE, POOL_A, POOL_D, POOL_WE, busy, done
  );

  modport slave (
    output start, RAM_Q,
    input  RAM_A, RAM_OE, POOL_A, POOL_D, POOL_WE, busy, done
  );
endinterface

// File: rtl/maxpool_relu_ctrl_pool_max_relu.sv
// Running signed maximum over one 2x2 window plus combinational ReLU.
//   clk, rst : clock, async active-low reset
//   load_i   : overwrite the maximum with din_i (first word of a window)
//   upd_i    : keep the signed max of the current maximum and din_i
//   din_i    : conv RAM read data
//   relu_o   : current maximum, or zero when it is negative
module pool_max_relu
  import maxpool_relu_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          upd_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] relu_o
);

  logic signed [DW-1:0] mx_q, mx_d;
  logic signed [DW-1:0] din_s;

  assign din_s = din_i;

  always_comb begin
    mx_d = mx_q;
    if (load_i)
      mx_d = din_s;
    else if (upd_i && (din_s > mx_q))
      mx_d = din_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mx_q <= '0;
    else      mx_q <= mx_d;
  end

  assign relu_o = mx_q[DW-1] ? DW'(RELU_ZERO) : mx_q;

endmodule

// File: rtl/maxpool_relu_ctrl.sv
// 2x2 stride-2 max-pool followed by ReLU over an IN_DIM x IN_DIM signed frame
// held in the conv RAM; writes the (IN_DIM/2)^2 result to the pool RAM.
// Each output pixel takes 5 READ cycles (4 issues, 4 captures offset by the
// one-cycle RAM latency) and 1 WRITE cycle.
//   clk, rst : clock, async active-low reset
//   bus      : start, conv RAM read port, pool RAM write port, busy/done
module maxpool_relu_ctrl
  import maxpool_relu_ctrl_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int IN_DIM = IN_DIM_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  maxpool_relu_ctrl_if.master  bus
);

  localparam int OD = IN_DIM / 2;
  localparam int PW = $clog2(OD);
  localparam int LW = $clog2(IN_DIM);

  state_e        state_q, state_d;
  logic [PW-1:0] pr_q, pr_d, pc_q, pc_d;
  logic [2:0]    k_q, k_d;
  logic          mx_load, mx_upd;
  logic [DW-1:0] relu;
  logic          issue, last_px;
  logic [AW-1:0] rd_addr, wr_addr;

  // k = 0..3 issue reads, k = 4 only captures the last word.
  assign issue   = (state_q == S_READ) && !k_q[2];
  assign last_px = (pr_q == '1) && (pc_q == '1);

  // Row term {pr,k[1]} = 2pr+k[1]; column term {pc,k[0]} = 2pc+k[0] < IN_DIM,
  // so it can be OR-ed under the row term shifted by log2(IN_DIM).
  assign rd_addr = (AW'({pr_q, k_q[1]}) << LW) | AW'({pc_q, k_q[0]});
  assign wr_addr = AW'({pr_q, pc_q});

  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    k_d     = k_q;
    mx_load = 1'b0;
    mx_upd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_READ;
      end
      S_READ: begin
        // RAM_Q now holds the word addressed when k was one lower.
        mx_load = (k_q == 3'd1);
        mx_upd  = (k_q >= 3'd2);
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = S_WRITE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_WRITE: begin
        pc_d = pc_q + 1'b1;
        if (pc_q == '1) pr_d = pr_q + 1'b1;
        state_d = last_px ? S_DONE : S_READ;
      end
      S_DONE: begin
        pr_d    = '0;
        pc_d    = '0;
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pr_q    <= '0;
      pc_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      pc_q    <= pc_d;
      k_q     <= k_d;
    end
  end

  pool_max_relu #(.DW(DW)) u_max (
    .clk    (clk),
    .rst    (rst),
    .load_i (mx_load),
    .upd_i  (mx_upd),
    .din_i  (bus.RAM_Q),
    .relu_o (relu)
  );

  // Outputs decode straight from registered state, so an async reset
  // silences every enable in the same instant.
  assign bus.RAM_OE  = issue;
  assign bus.RAM_A   = issue ? rd_addr : '0;
  assign bus.POOL_WE = (state_q == S_WRITE);
  assign bus.POOL_A  = (state_q == S_WRITE) ? wr_addr : '0;
  assign bus.POOL_D  = (state_q == S_WRITE) ? relu : '0;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_maxpool_relu_ctrl.sv
// Self-checking bench for maxpool_relu_ctrl. Runs the design with a 64x64
// frame so full-frame and back-to-back runs stay short; every window and
// wrap check is expressed in terms of IN/OD.
module tb_maxpool_relu_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 20;
  localparam int IN    = 64;
  localparam int OD    = IN / 2;
  localparam int NPIX  = OD * OD;
  localparam int D_CYC = 6 * NPIX + 1;   // cycle carrying done

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  wr_t  sb[$];
  logic [DW-1:0] mem [IN*IN];

  always #5 clk = ~clk;

  maxpool_relu_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  maxpool_relu_ctrl #(.DW(DW), .AW(AW), .IN_DIM(IN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Conv RAM model: one-cycle read latency.
  initial bus.RAM_Q = '0;
  always @(posedge clk)
    if (bus.RAM_OE) bus.RAM_Q <= mem[int'(bus.RAM_A)];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  function automatic wr_t exp_px(int p);
    wr_t e;
    int pr, pc;
    pr  = p / OD;
    pc  = p % OD;
    e.a = AW'(p);
    e.d = DW'(((2*pr + 1) * IN + 2*pc + 1) % 32768);
    return e;
  endfunction

  task automatic fill_pattern();
    for (int a = 0; a < IN*IN; a++) mem[a] = DW'(a % 32768);
  endtask

  task automatic fill_zero();
    for (int a = 0; a < IN*IN; a++) mem[a] = '0;
  endtask

  // Advance to the next falling edge and retire any pool write against the
  // scoreboard.
  task automatic step_cycle();
    wr_t e;
    @(negedge clk);
    if (bus.POOL_WE === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_spurious: write a=%0d d=%0d, required no write", bus.POOL_A, bus.POOL_D);
      end else begin
        e = sb.pop_front();
        if (bus.POOL_A !== e.a || bus.POOL_D !== e.d) begin
          errors++;
          $display("FAIL sb_write: got a=%0d d=%0d, required a=%0d d=%0d",
                   bus.POOL_A, $signed(bus.POOL_D), e.a, $signed(e.d));
        end
      end
    end
  endtask

  // Start sampled at edge 0; returns in cycle 1.
  task automatic start_frame();
    bus.start = 1'b1;
    step_cycle();
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step_cycle();
    step_cycle();
    rst = 1'b1;
    step_cycle();
    sb.delete();
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checks++;
      if ({bus.RAM_A, bus.RAM_OE, bus.POOL_A, bus.POOL_D, bus.POOL_WE, bus.busy, bus.done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: oe=%b we=%b busy=%b done=%b ra=%0d pa=%0d pd=%0d, required all 0",
                 bus.RAM_OE, bus.POOL_WE, bus.busy, bus.done, bus.RAM_A, bus.POOL_A, bus.POOL_D);
      end
    end
    bus.start = 1'b0;
    rst = 1'b1;
    step_cycle();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_single_window();
    fill_zero();
    mem[0] = 16'sd5;  mem[1] = -16'sd3;
    mem[IN] = 16'sd9; mem[IN+1] = 16'sd2;
    sb.push_back('{a: '0, d: DW'(9)});
    start_frame();
    checks++;
    if (bus.RAM_OE !== 1'b1 || bus.RAM_A !== '0) begin
      errors++;
      $display("FAIL single_first_read: oe=%b a=%0d, required oe=1 a=0", bus.RAM_OE, bus.RAM_A);
    end
    while (cyc < 6) begin step_cycle(); cyc++; end
    checks++;
    if (bus.POOL_WE !== 1'b1) begin
      errors++;
      $display("FAIL single_we_cycle6: we=%b, required 1", bus.POOL_WE);
    end
    do_reset();
  endtask

  task automatic test_relu();
    fill_zero();
    mem[0] = -16'sd1;  mem[1] = -16'sd7;
    mem[IN] = -16'sd2; mem[IN+1] = -16'sd100;
    sb.push_back('{a: '0, d: '0});
    start_frame();
    while (cyc < 6) begin step_cycle(); cyc++; end
    checks++;
    if (bus.POOL_WE !== 1'b1 || bus.POOL_D !== '0) begin
      errors++;
      $display("FAIL relu_zero: we=%b d=%0d, required we=1 d=0", bus.POOL_WE, $signed(bus.POOL_D));
    end
    do_reset();
  endtask

  task automatic test_col_wrap();
    logic [AW-1:0] ea [2][4];
    int b;
    fill_pattern();
    b = 2 * (OD - 1);
    ea[0][0] = AW'(b);        ea[0][1] = AW'(b + 1);
    ea[0][2] = AW'(b + IN);   ea[0][3] = AW'(b + IN + 1);
    ea[1][0] = AW'(2*IN);     ea[1][1] = AW'(2*IN + 1);
    ea[1][2] = AW'(3*IN);     ea[1][3] = AW'(3*IN + 1);
    for (int p = 0; p <= OD; p++) sb.push_back(exp_px(p));
    start_frame();
    while (cyc <= 6 * (OD + 1)) begin
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 4; k++)
          if (cyc == 6 * (OD - 1 + j) + 1 + k) begin
            checks++;
            if (bus.RAM_OE !== 1'b1 || bus.RAM_A !== ea[j][k]) begin
              errors++;
              $display("FAIL wrap_read px%0d k%0d: oe=%b a=%0d, required oe=1 a=%0d",
                       OD - 1 + j, k, bus.RAM_OE, bus.RAM_A, ea[j][k]);
            end
          end
      step_cycle();
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_writes: %0d writes outstanding, required 0", sb.size());
    end
    do_reset();
  endtask

  task automatic test_full_frame();
    int extra_done = 0;
    fill_pattern();
    for (int p = 0; p < NPIX; p++) sb.push_back(exp_px(p));
    start_frame();
    while (cyc < D_CYC + 1) begin
      bus.start = (cyc == 100 || cyc == 3001 || cyc == 6 * NPIX - 3);
      step_cycle();
      cyc++;
      if (cyc == D_CYC) begin
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL frame_done: done=%b busy=%b at cycle %0d, required 1 1", bus.done, bus.busy, cyc);
        end
      end else if (bus.done === 1'b1) begin
        extra_done++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL frame_idle: busy=%b done=%b at cycle %0d, required 0 0", bus.busy, bus.done, cyc);
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL frame_extra_done: %0d stray pulses, required 0", extra_done);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL frame_writes: %0d writes outstanding, required 0", sb.size());
    end
    step_cycle();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_restart: busy=%b after frame, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < NPIX; p++) sb.push_back(exp_px(p));
    start_frame();
    while (cyc < D_CYC) begin
      bus.start = (cyc >= D_CYC - 2);
      step_cycle();
      cyc++;
    end
    // cycle D_CYC: DONE, start held high
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b, required 1", bus.done);
    end
    step_cycle(); cyc++;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, required 0", bus.busy);
    end
    step_cycle(); cyc++;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.RAM_OE !== 1'b1 || bus.RAM_A !== '0) begin
      errors++;
      $display("FAIL b2b_relaunch: busy=%b oe=%b a=%0d, required 1 1 0", bus.busy, bus.RAM_OE, bus.RAM_A);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_writes: %0d writes outstanding, required 0", sb.size());
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    fill_pattern();
    for (int p = 0; p < 5; p++) sb.push_back(exp_px(p));
    start_frame();
    while (cyc < 33) begin step_cycle(); cyc++; end
    // pixel 5, k=2: bottom-left of window (0,5)
    checks++;
    if (bus.RAM_OE !== 1'b1 || bus.RAM_A !== AW'(IN + 10)) begin
      errors++;
      $display("FAIL mid_read: oe=%b a=%0d, required oe=1 a=%0d", bus.RAM_OE, bus.RAM_A, IN + 10);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.POOL_WE !== 1'b0 || bus.RAM_OE !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: busy=%b we=%b oe=%b, required 0 0 0", bus.busy, bus.POOL_WE, bus.RAM_OE);
    end
    for (int i = 0; i < 8; i++) step_cycle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step_cycle();
    checks++;
    if (sb.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet: outstanding=%0d busy=%b, required 0 0", sb.size(), bus.busy);
    end
    sb.push_back(exp_px(0));
    start_frame();
    while (cyc < 6) begin step_cycle(); cyc++; end
    checks++;
    if (bus.POOL_WE !== 1'b1 || bus.POOL_A !== '0) begin
      errors++;
      $display("FAIL mid_restart: we=%b a=%0d, required we=1 a=0", bus.POOL_WE, bus.POOL_A);
    end
    do_reset();
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_single_window();
    test_relu();
    test_col_wrap();
    test_full_frame();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxpool_relu_ctrl.md
# maxpool_relu_ctrl

- Downstream stage of the 3x3 convolution controller. Starts on that controller's `done` pulse.
- Reads the 256x256 signed convolution result from the conv output RAM and applies a 2x2, stride-2 max-pool followed by ReLU.
- Writes the 128x128 result to a separate pool RAM, then pulses `done`.

## Interface

Parameters:
- `DW`, 16: result word width, signed two's complement.
- `AW`, 20: address width, matching the conv RAM address bus.
- `IN_DIM`, 256: input frame edge. Power of two. Output edge is `IN_DIM/2`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled in IDLE; typically the conv controller's `done`.
- `RAM_Q` in DW: conv RAM read data.
- `RAM_A` out AW: conv RAM read address.
- `RAM_OE` out 1: conv RAM read enable.
- `POOL_A` out AW: pool RAM write address.
- `POOL_D` out DW: pool RAM write data.
- `POOL_WE` out 1: pool RAM write enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation

- States and transitions:
  - IDLE → READ when `start`=1.
  - READ → WRITE when `k`=4.
  - WRITE → DONE after the last pixel; otherwise WRITE → READ.
  - DONE → IDLE unconditionally.
- Registers:
  - `pr`, `pc`: output row/column, each log2(IN_DIM/2) bits.
  - `k`: READ counter, 0..4, 3 bits.
  - `mx`: running maximum, DW bits, signed.
- READ issue phase, `k`=0..3:
  - `RAM_OE`=1.
  - `RAM_A` = (2·pr + k[1])·IN_DIM + 2·pc + k[0].
  - Order is top-left, top-right, bottom-left, bottom-right.
- READ capture phase, `k`=1..4: `RAM_Q` holds the word addressed in cycle `k`-1.
  - At `k`=1: `mx` ← `RAM_Q`.
  - At `k`=2..4: `mx` ← signed max(`mx`, `RAM_Q`).
- WRITE, one cycle:
  - `POOL_WE`=1, `POOL_A` = pr·(IN_DIM/2) + pc.
  - `POOL_D` = `mx` if `mx`[DW-1]=0, else 0 (ReLU).
  - Then `pc`+1. When `pc` = IN_DIM/2−1 it wraps to 0 and `pr`+1.
- Last pixel: the WRITE with `pr` = `pc` = IN_DIM/2−1 goes to DONE. DONE clears `pr`, `pc`, `k`.
- `start` is ignored outside IDLE. `start` held high through DONE launches a new frame from IDLE on the next cycle.
- Address arithmetic is unsigned, zero-extended to AW. No address ever exceeds IN_DIM²−1.

## Timing

- All outputs are 0 after reset.
- Outside their active state, address, data and enable outputs are driven to 0.
- Conv RAM read latency is exactly one cycle: address/OE in cycle n, data valid in cycle n+1.
- Per output pixel: 5 READ cycles + 1 WRITE cycle = 6 cycles, with no overlap between pixels.
- Frame timing, with `start` sampled at edge 0:
  - First READ cycle is cycle 1.
  - First WRITE is cycle 6.
  - Last WRITE is cycle 6·(IN_DIM/2)² = 98304.
  - `done`=1 in cycle 98305, `busy`=0 from cycle 98306.
- Reset asserted mid-operation:
  - Immediate return to IDLE; all registers cleared.
  - No partial `POOL_WE` is issued.
  - A subsequent `start` restarts from pixel 0.

## Structure

- Shared package holds:
  - State encoding: IDLE, READ, WRITE, DONE as a 2-bit enum.
  - Default widths for DW/AW.
  - ReLU zero constant.
- One natural sub-module, `pool_max_relu`:
  - Holds the `mx` register with load/update controls and the signed comparator.
  - Produces the ReLU output combinationally.
- FSM, counters and address generation stay in the top module.

## Test plan

- **Reset:** hold `rst`=0 with `start`=1 → every output 0 and `busy`=0 until release.
- **Single window:** mem[0]=5, mem[1]=−3, mem[256]=9, mem[257]=2, pulse `start` → cycle 6: `POOL_WE`=1, `POOL_A`=0, `POOL_D`=9.
- **ReLU:** window of pixel 0 = {−1, −7, −2, −100} → `POOL_D`=0.
- **Column wrap:**
  - Pixel 127 reads addresses 254, 255, 510, 511 and writes `POOL_A`=127.
  - Pixel 128 reads addresses 512, 513, 768, 769.
- **Full frame:** mem[a] = a mod 2^15 → 16384 writes, each `POOL_D` = (2pr+1)·256+2pc+1 mod 2^15; `done` pulse at cycle 98305; `start` pulses while busy have no effect.
- **Reset mid-op:** `rst`=0 during READ `k`=2 of pixel 5, then release and restart → no spurious write; first write is `POOL_A`=0 at cycle 6 after the new `start`.
